// File: rtl/apb_master.sv
// apb_master
//   Single-outstanding APB requester. A command accepted on the valid/ready
//   port is registered and played out as one APB SETUP + ACCESS transfer.
//   Each transfer ends with a one-cycle response strobe that carries either
//   the read data or a timeout indication.
//
// Ports
//   PCLK, PRESET_n            clock (rising edge), async active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake; ready is high only in IDLE
//   cmd_write_i               1 = write, 0 = read
//   cmd_addr_i, cmd_wdata_i   target address and write data
//   rsp_valid_o               one-cycle completion strobe
//   rsp_rdata_o               read data (forced to 0 for writes and timeouts)
//   rsp_timeout_o             transfer was aborted by the wait timeout
//   PSEL_o, PENABLE_o         APB phase control
//   PWRITE_o, PADDR_o         APB direction and address
//   PWDATA_o                  APB write data
//   PRDATA_i, PREADY_i        APB completer read data and ready
module apb_master #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_timeout_o,
  output logic              PSEL_o,
  output logic              PENABLE_o,
  output logic              PWRITE_o,
  output logic [ADDR_W-1:0] PADDR_o,
  output logic [DATA_W-1:0] PWDATA_o,
  input  logic [DATA_W-1:0] PRDATA_i,
  input  logic              PREADY_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value during the last ACCESS cycle the completer is allowed.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             complete;
  logic             abort;

  // State register; reset forces IDLE so the bus is released at once.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the phase outputs, which follow the state
  // directly so a reset drops PSEL/PENABLE without waiting for an edge.
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    complete    = 1'b0;
    abort       = 1'b0;
    cmd_ready_o = 1'b0;
    PSEL_o      = 1'b0;
    PENABLE_o   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          accept     = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: begin
        PSEL_o     = 1'b1;
        next_state = ACCESS;
      end
      ACCESS: begin
        PSEL_o    = 1'b1;
        PENABLE_o = 1'b1;
        if (PREADY_i) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Command capture, wait counting and response registers. The captured
  // command stays on the bus after the transfer until the next accept.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      PWRITE_o      <= 1'b0;
      PADDR_o       <= '0;
      PWDATA_o      <= '0;
      wait_cnt      <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      rsp_valid_o <= complete | abort;
      if (accept) begin
        PWRITE_o <= cmd_write_i;
        PADDR_o  <= cmd_addr_i;
        PWDATA_o <= cmd_wdata_i;
        wait_cnt <= '0;
      end else if (state == ACCESS && !PREADY_i) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (complete) begin
        rsp_rdata_o   <= PWRITE_o ? '0 : PRDATA_i;
        rsp_timeout_o <= 1'b0;
      end else if (abort) begin
        rsp_rdata_o   <= '0;
        rsp_timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master
//   Directed bench for apb_master (ADDR_W=9, DATA_W=8, TIMEOUT_CYCLES=16).
//   Inputs change 1 time unit after each rising edge and outputs are
//   sampled at the same point, so every sample shows one full cycle.
module tb_apb_master;

  logic       PCLK = 1'b0;
  logic       PRESET_n;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic       cmd_write_i;
  logic [8:0] cmd_addr_i;
  logic [7:0] cmd_wdata_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_rdata_o;
  logic       rsp_timeout_o;
  logic       PSEL_o;
  logic       PENABLE_o;
  logic       PWRITE_o;
  logic [8:0] PADDR_o;
  logic [7:0] PWDATA_o;
  logic [7:0] PRDATA_i;
  logic       PREADY_i;

  int compared   = 0;
  int mismatched = 0;

  apb_master #(
    .ADDR_W         (9),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK          (PCLK),
    .PRESET_n      (PRESET_n),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_write_i   (cmd_write_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_wdata_i   (cmd_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_timeout_o (rsp_timeout_o),
    .PSEL_o        (PSEL_o),
    .PENABLE_o     (PENABLE_o),
    .PWRITE_o      (PWRITE_o),
    .PADDR_o       (PADDR_o),
    .PWDATA_o      (PWDATA_o),
    .PRDATA_i      (PRDATA_i),
    .PREADY_i      (PREADY_i)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic write,
                                input logic [8:0] addr, input logic [7:0] wdata,
                                input logic pready, input logic [7:0] prdata);
    cmd_valid_i = valid;
    cmd_write_i = write;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    PREADY_i    = pready;
    PRDATA_i    = prdata;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset values
    PRESET_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 8'h00);
    tick();
    tick();
    check_output("rst_ready",   32'(cmd_ready_o),   1);
    check_output("rst_rvalid",  32'(rsp_valid_o),   0);
    check_output("rst_rdata",   32'(rsp_rdata_o),   0);
    check_output("rst_timeout", 32'(rsp_timeout_o), 0);
    check_output("rst_psel",    32'(PSEL_o),        0);
    check_output("rst_penable", 32'(PENABLE_o),     0);
    check_output("rst_pwrite",  32'(PWRITE_o),      0);
    check_output("rst_paddr",   32'(PADDR_o),       0);
    check_output("rst_pwdata",  32'(PWDATA_o),      0);
    PRESET_n = 1'b1;
    tick();

    // Write 0x3C to 0x002, zero-wait completer. PREADY high during
    // SETUP must be ignored.
    apply_stimulus(1'b1, 1'b1, 9'h002, 8'h3C, 1'b1, 8'h00);
    check_output("wr_k_ready", 32'(cmd_ready_o), 1);
    check_output("wr_k_psel",  32'(PSEL_o),      0);
    tick();
    apply_stimulus(1'b0, 1'b0, 9'h1FF, 8'hFF, 1'b1, 8'h00);
    check_output("wr_k1_psel",    32'(PSEL_o),      1);
    check_output("wr_k1_penable", 32'(PENABLE_o),   0);
    check_output("wr_k1_ready",   32'(cmd_ready_o), 0);
    check_output("wr_k1_paddr",   32'(PADDR_o),     32'h002);
    check_output("wr_k1_pwdata",  32'(PWDATA_o),    32'h3C);
    check_output("wr_k1_pwrite",  32'(PWRITE_o),    1);
    tick();
    check_output("wr_k2_psel",    32'(PSEL_o),      1);
    check_output("wr_k2_penable", 32'(PENABLE_o),   1);
    check_output("wr_k2_paddr",   32'(PADDR_o),     32'h002);
    check_output("wr_k2_pwdata",  32'(PWDATA_o),    32'h3C);
    check_output("wr_k2_rvalid",  32'(rsp_valid_o), 0);
    tick();
    apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 8'h00);
    check_output("wr_k3_rvalid",  32'(rsp_valid_o),   1);
    check_output("wr_k3_timeout", 32'(rsp_timeout_o), 0);
    check_output("wr_k3_rdata",   32'(rsp_rdata_o),   0);
    check_output("wr_k3_psel",    32'(PSEL_o),        0);
    check_output("wr_k3_ready",   32'(cmd_ready_o),   1);
    check_output("wr_k3_paddr",   32'(PADDR_o),       32'h002);
    tick();
    check_output("wr_k4_rvalid", 32'(rsp_valid_o), 0);

    // Read 0x002 with two wait states; PRDATA changes to 0x28 only in
    // the completing cycle.
    apply_stimulus(1'b1, 1'b0, 9'h002, 8'h00, 1'b0, 8'h55);
    tick();
    apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 8'h55);
    check_output("rd_k1_psel",   32'(PSEL_o),   1);
    check_output("rd_k1_pwrite", 32'(PWRITE_o), 0);
    tick();
    check_output("rd_k2_penable", 32'(PENABLE_o), 1);
    tick();
    check_output("rd_k3_penable", 32'(PENABLE_o),   1);
    check_output("rd_k3_rvalid",  32'(rsp_valid_o), 0);
    tick();
    apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 8'h28);
    check_output("rd_k4_rvalid", 32'(rsp_valid_o), 0);
    tick();
    apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 8'h00);
    check_output("rd_k5_rvalid",  32'(rsp_valid_o),   1);
    check_output("rd_k5_rdata",   32'(rsp_rdata_o),   32'h28);
    check_output("rd_k5_timeout", 32'(rsp_timeout_o), 0);
    tick();

    // PREADY stuck low: abort after the 16th ACCESS cycle.
    apply_stimulus(1'b1, 1'b0, 9'h0AB, 8'h00, 1'b0, 8'h99);
    tick();
    apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 8'h99);
    for (int i = 0; i < 16; i++) begin
      tick();
      check_output("to_access_penable", 32'(PENABLE_o),   1);
      check_output("to_access_rvalid",  32'(rsp_valid_o), 0);
    end
    tick();
    check_output("to_k18_psel",    32'(PSEL_o),        0);
    check_output("to_k18_rvalid",  32'(rsp_valid_o),   1);
    check_output("to_k18_timeout", 32'(rsp_timeout_o), 1);
    check_output("to_k18_rdata",   32'(rsp_rdata_o),   0);
    tick();
    check_output("to_k19_rvalid",  32'(rsp_valid_o),   0);
    check_output("to_k19_timeout", 32'(rsp_timeout_o), 1);

    // PREADY high in the 16th ACCESS cycle completes normally.
    apply_stimulus(1'b1, 1'b0, 9'h0CD, 8'h00, 1'b0, 8'h5A);
    tick();
    apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 8'h5A);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 15) apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 8'h5A);
      check_output("last_access_penable", 32'(PENABLE_o), 1);
    end
    tick();
    apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 8'h00);
    check_output("last_k18_rvalid",  32'(rsp_valid_o),   1);
    check_output("last_k18_timeout", 32'(rsp_timeout_o), 0);
    check_output("last_k18_rdata",   32'(rsp_rdata_o),   32'h5A);
    tick();

    // Back-to-back: valid held high, write 0x011 then read 0x011.
    apply_stimulus(1'b1, 1'b1, 9'h011, 8'hA5, 1'b1, 8'h77);
    tick();
    apply_stimulus(1'b1, 1'b0, 9'h011, 8'h00, 1'b1, 8'h77);
    check_output("b2b_k1_ready",  32'(cmd_ready_o), 0);
    check_output("b2b_k1_pwrite", 32'(PWRITE_o),    1);
    check_output("b2b_k1_pwdata", 32'(PWDATA_o),    32'hA5);
    tick();
    check_output("b2b_k2_ready", 32'(cmd_ready_o), 0);
    tick();
    check_output("b2b_k3_rvalid",  32'(rsp_valid_o),   1);
    check_output("b2b_k3_ready",   32'(cmd_ready_o),   1);
    check_output("b2b_k3_rdata",   32'(rsp_rdata_o),   0);
    check_output("b2b_k3_timeout", 32'(rsp_timeout_o), 0);
    tick();
    apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 8'h77);
    check_output("b2b_k4_rvalid",  32'(rsp_valid_o), 0);
    check_output("b2b_k4_psel",    32'(PSEL_o),      1);
    check_output("b2b_k4_penable", 32'(PENABLE_o),   0);
    check_output("b2b_k4_pwrite",  32'(PWRITE_o),    0);
    check_output("b2b_k4_paddr",   32'(PADDR_o),     32'h011);
    tick();
    check_output("b2b_k5_ready",   32'(cmd_ready_o), 0);
    check_output("b2b_k5_penable", 32'(PENABLE_o),   1);
    tick();
    apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 8'h00);
    check_output("b2b_k6_rvalid", 32'(rsp_valid_o), 1);
    check_output("b2b_k6_rdata",  32'(rsp_rdata_o), 32'h77);
    tick();

    // Reset asserted mid-ACCESS: bus released without waiting for an edge,
    // and no response follows once reset is released.
    apply_stimulus(1'b1, 1'b1, 9'h1F0, 8'hC3, 1'b0, 8'h00);
    tick();
    apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 8'h00);
    tick();
    tick();
    check_output("mrst_pre_penable", 32'(PENABLE_o), 1);
    #1 PRESET_n = 1'b0;
    #1;
    check_output("mrst_psel",    32'(PSEL_o),      0);
    check_output("mrst_penable", 32'(PENABLE_o),   0);
    check_output("mrst_ready",   32'(cmd_ready_o), 1);
    check_output("mrst_paddr",   32'(PADDR_o),     0);
    check_output("mrst_pwdata",  32'(PWDATA_o),    0);
    check_output("mrst_pwrite",  32'(PWRITE_o),    0);
    check_output("mrst_rdata",   32'(rsp_rdata_o), 0);
    #1 PRESET_n = 1'b1;
    apply_stimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 8'hEE);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("mrst_after_rvalid", 32'(rsp_valid_o), 0);
      check_output("mrst_after_ready",  32'(cmd_ready_o), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
